theory_multiplier_8bit: RTL

THEORY_MULTIPLIER_8BIT -- requirements
Module: theory_multiplier_8bit

---
 rtl/theory_multiplier_8bit.sv | 92 +++++++++
 1 files changed

// File: rtl/theory_multiplier_8bit.sv
// theory_multiplier_8bit: 9-cycle shift-add 8x8 multiplier with IDLE/CALC/FIX FSM.
// Define THEORY_MULT_SIGNED_EN for two's-complement operands; default build is unsigned.
module theory_multiplier_8bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_sig,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic        busy,
    output logic        done_sig,
    output logic [15:0] product
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic        sign_q, sign_d;
    logic [15:0] acc_q, acc_d, product_q, product_d;
    logic        done_q, done_d;
    logic [7:0]  in_mag_a, in_mag_b;
    logic        in_sign;

`ifdef THEORY_MULT_SIGNED_EN
    // 0x80 maps to 128, which still fits the 8-bit unsigned magnitude
    assign in_mag_a = multiplicand[7] ? ~multiplicand + 8'd1 : multiplicand;
    assign in_mag_b = multiplier[7] ? ~multiplier + 8'd1 : multiplier;
    assign in_sign  = multiplicand[7] ^ multiplier[7];
`else
    assign in_mag_a = multiplicand;
    assign in_mag_b = multiplier;
    assign in_sign  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        sign_d    = sign_q;
        acc_d     = acc_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (start_sig) begin
                state_d = CALC;
                cnt_d   = 3'd0;
                mag_a_d = in_mag_a;
                mag_b_d = in_mag_b;
                sign_d  = in_sign;
                acc_d   = 16'd0;
            end
            CALC: begin
                acc_d   = mag_a_q[cnt_q] ? acc_q + ({8'd0, mag_b_q} << cnt_q) : acc_q;
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == 3'd7) ? FIX : CALC;
            end
            FIX: begin
                product_d = sign_q ? ~acc_q + 16'd1 : acc_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            mag_a_q   <= 8'd0;
            mag_b_q   <= 8'd0;
            sign_q    <= 1'b0;
            acc_q     <= 16'd0;
            product_q <= 16'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            sign_q    <= sign_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done_sig = done_q;
    assign product  = product_q;
endmodule
